// File: rtl/cordic_result_buffer.sv
// Result FIFO behind the CORDIC core: captures tagged (x, y) pairs and drains them via valid/ready.
// Define CORDIC_RESBUF_PARITY_EN to add a stored even-parity bit per entry and the out_parity port.
module cordic_result_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] result_x,
    input  logic [DATA_WIDTH-1:0] result_y,
    input  logic                  compute_done,
    input  logic [1:0]            cordic_mode,
    input  logic                  clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic [1:0]            out_mode,
    output logic [AW:0]           fill_level,
    output logic                  full,
    output logic [CNT_WIDTH-1:0]  overflow_cnt
`ifdef CORDIC_RESBUF_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

    logic [DATA_WIDTH-1:0] mem_x    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_y    [FIFO_DEPTH];
    logic [1:0]            mem_mode [FIFO_DEPTH];
`ifdef CORDIC_RESBUF_PARITY_EN
    logic                  mem_par  [FIFO_DEPTH];
`endif

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;

    always_comb begin
        out_valid = (fill_level != '0);
        full      = (fill_level == DEPTH_L);
    end

    // clear suppresses every other action in its cycle
    always_comb begin
        pop  = out_valid && out_ready && !clear;
        push = compute_done && !clear && (!full || pop);
        drop = compute_done && !clear && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr]    <= result_x;
            mem_y[wr_ptr]    <= result_y;
            mem_mode[wr_ptr] <= cordic_mode;
`ifdef CORDIC_RESBUF_PARITY_EN
            mem_par[wr_ptr]  <= ^{result_x, result_y, cordic_mode};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_level   <= '0;
            overflow_cnt <= '0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_level   <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fill_level <= fill_level + 1'b1;
            else if (pop && !push)
                fill_level <= fill_level - 1'b1;
            if (drop && (overflow_cnt != '1))
                overflow_cnt <= overflow_cnt + 1'b1;
        end
    end

    // Show-ahead head; forced to zero when empty so stale storage never leaks out
    always_comb begin
        out_x    = '0;
        out_y    = '0;
        out_mode = '0;
`ifdef CORDIC_RESBUF_PARITY_EN
        out_parity = 1'b0;
`endif
        if (out_valid) begin
            out_x    = mem_x[rd_ptr];
            out_y    = mem_y[rd_ptr];
            out_mode = mem_mode[rd_ptr];
`ifdef CORDIC_RESBUF_PARITY_EN
            out_parity = mem_par[rd_ptr];
`endif
        end
    end

endmodule

// File: tb/tb_cordic_result_buffer.sv
// Directed self-checking bench for cordic_result_buffer (DATA_WIDTH=16, FIFO_DEPTH=4, CNT_WIDTH=8).
module tb_cordic_result_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] result_x;
    logic [15:0] result_y;
    logic        compute_done;
    logic [1:0]  cordic_mode;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic [1:0]  out_mode;
    logic [2:0]  fill_level;
    logic        full;
    logic [7:0]  overflow_cnt;
`ifdef CORDIC_RESBUF_PARITY_EN
    logic        out_parity;
`endif

    int checks   = 0;
    int failures = 0;

    cordic_result_buffer #(
        .DATA_WIDTH(16),
        .FIFO_DEPTH(4),
        .CNT_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .result_x    (result_x),
        .result_y    (result_y),
        .compute_done(compute_done),
        .cordic_mode (cordic_mode),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_mode    (out_mode),
        .fill_level  (fill_level),
        .full        (full),
        .overflow_cnt(overflow_cnt)
`ifdef CORDIC_RESBUF_PARITY_EN
        ,
        .out_parity  (out_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        compute_done = 1'b0;
        out_ready    = 1'b0;
        clear        = 1'b0;
        result_x     = '0;
        result_y     = '0;
        cordic_mode  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || fill_level !== 3'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: valid=%b fill=%0d full=%b, want 0 0 0", out_valid, fill_level, full);
        end
        checks++;
        if (out_x !== 16'h0 || out_y !== 16'h0 || out_mode !== 2'd0 || overflow_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_data: x=%h y=%h mode=%0d ovf=%0d, want all 0", out_x, out_y, out_mode, overflow_cnt);
        end
        rst_n = 1'b1;
        #3;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || fill_level !== 3'd0) begin
            failures++;
            $display("FAIL ready_when_empty: valid=%b fill=%0d, want 0 0", out_valid, fill_level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_single_push();
        result_x = 16'h1234; result_y = 16'hABCD; cordic_mode = 2'b01; compute_done = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_bypass: valid=%b, want 0", out_valid);
        end
        tick();
        compute_done = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_x !== 16'h1234 || out_y !== 16'hABCD || out_mode !== 2'd1 || fill_level !== 3'd1) begin
            failures++;
            $display("FAIL single_push: valid=%b x=%h y=%h mode=%0d fill=%0d, want 1 1234 abcd 1 1",
                     out_valid, out_x, out_y, out_mode, fill_level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || fill_level !== 3'd0 || out_x !== 16'h0) begin
            failures++;
            $display("FAIL single_pop: valid=%b fill=%0d x=%h, want 0 0 0000", out_valid, fill_level, out_x);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 6; i++) begin
            result_x = 16'(i); result_y = 16'(16'h100 + i); cordic_mode = 2'(i); compute_done = 1'b1;
            tick();
        end
        compute_done = 1'b0;
        checks++;
        if (fill_level !== 3'd4 || full !== 1'b1 || overflow_cnt !== 8'd2 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL overflow_fill: fill=%0d full=%b ovf=%0d valid=%b, want 4 1 2 1",
                     fill_level, full, overflow_cnt, out_valid);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_x !== 16'(i) || out_y !== 16'(16'h100 + i) || out_mode !== 2'(i)) begin
                failures++;
                $display("FAIL drain_order_%0d: valid=%b x=%h y=%h mode=%0d, want 1 %h %h %0d",
                         i, out_valid, out_x, out_y, out_mode, 16'(i), 16'(16'h100 + i), i % 4);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || fill_level !== 3'd0 || overflow_cnt !== 8'd2) begin
            failures++;
            $display("FAIL drain_empty: valid=%b fill=%0d ovf=%0d, want 0 0 2", out_valid, fill_level, overflow_cnt);
        end
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < 4; i++) begin
            result_x = 16'(16'h10 + i); compute_done = 1'b1;
            tick();
        end
        result_x = 16'h00AA; out_ready = 1'b1;
        tick();
        compute_done = 1'b0;
        checks++;
        if (fill_level !== 3'd4 || full !== 1'b1 || overflow_cnt !== 8'd2 || out_x !== 16'h0011) begin
            failures++;
            $display("FAIL push_pop_full: fill=%0d full=%b ovf=%0d x=%h, want 4 1 2 0011",
                     fill_level, full, overflow_cnt, out_x);
        end
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_x;
            exp_x = (i == 3) ? 16'h00AA : 16'(16'h11 + i);
            checks++;
            if (out_valid !== 1'b1 || out_x !== exp_x) begin
                failures++;
                $display("FAIL push_pop_order_%0d: valid=%b x=%h, want 1 %h", i, out_valid, out_x, exp_x);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturate_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (overflow_cnt !== 8'd0 || fill_level !== 3'd0) begin
            failures++;
            $display("FAIL clear_counter: ovf=%0d fill=%0d, want 0 0", overflow_cnt, fill_level);
        end
        compute_done = 1'b1;
        for (int i = 0; i < 4 + 254; i++) begin
            result_x = 16'(i);
            tick();
        end
        checks++;
        if (overflow_cnt !== 8'hFE || out_x !== 16'h0) begin
            failures++;
            $display("FAIL ovf_254: ovf=%h head=%h, want fe 0000", overflow_cnt, out_x);
        end
        tick();
        checks++;
        if (overflow_cnt !== 8'hFF) begin
            failures++;
            $display("FAIL ovf_255: ovf=%h, want ff", overflow_cnt);
        end
        for (int i = 0; i < 45; i++) tick();
        checks++;
        if (overflow_cnt !== 8'hFF || fill_level !== 3'd4) begin
            failures++;
            $display("FAIL ovf_saturate: ovf=%h fill=%0d, want ff 4", overflow_cnt, fill_level);
        end
        clear = 1'b1; out_ready = 1'b1;
        tick();
        clear = 1'b0; out_ready = 1'b0; compute_done = 1'b0;
        checks++;
        if (fill_level !== 3'd0 || out_valid !== 1'b0 || overflow_cnt !== 8'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL clear_priority: fill=%0d valid=%b ovf=%0d full=%b, want 0 0 0 0",
                     fill_level, out_valid, overflow_cnt, full);
        end
    endtask

    task automatic test_back_to_back();
        int recv = 0;
        bit level_ok = 1'b1;
        out_ready = 1'b1; compute_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            result_x = 16'(16'h200 + i);
            tick();
            if (fill_level > 3'd1) level_ok = 1'b0;
            if (out_valid === 1'b1 && out_x === 16'(16'h200 + recv)) recv++;
        end
        compute_done = 1'b0;
        tick();
        checks++;
        if (!level_ok || recv != 20 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back: level_ok=%0d recv=%0d valid=%b, want 1 20 0", level_ok, recv, out_valid);
        end
        compute_done = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            result_x = 16'(16'h300 + i);
            tick();
        end
        compute_done = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fill_level !== 3'd0 || out_x !== 16'h0) begin
            failures++;
            $display("FAIL async_reset: valid=%b fill=%0d x=%h, want 0 0 0000", out_valid, fill_level, out_x);
        end
        #3;
        rst_n = 1'b1;
        #1;
        result_x = 16'h0777; result_y = 16'h0888; cordic_mode = 2'd3; compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_x !== 16'h0777 || out_y !== 16'h0888 || out_mode !== 2'd3 || fill_level !== 3'd1) begin
            failures++;
            $display("FAIL push_after_reset: valid=%b x=%h y=%h mode=%0d fill=%0d, want 1 0777 0888 3 1",
                     out_valid, out_x, out_y, out_mode, fill_level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

`ifdef CORDIC_RESBUF_PARITY_EN
    task automatic test_parity();
        result_x = 16'h0001; result_y = 16'h0; cordic_mode = 2'd0; compute_done = 1'b1;
        tick();
        result_x = 16'h0003;
        tick();
        compute_done = 1'b0;
        checks++;
        if (out_parity !== 1'b1) begin
            failures++;
            $display("FAIL parity_odd: parity=%b, want 1", out_parity);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_parity !== 1'b0 || out_x !== 16'h0003) begin
            failures++;
            $display("FAIL parity_even: parity=%b x=%h, want 0 0003", out_parity, out_x);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_parity !== 1'b0) begin
            failures++;
            $display("FAIL parity_empty: parity=%b, want 0", out_parity);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_push();
        test_overflow();
        test_push_pop_full();
        test_saturate_clear();
        test_back_to_back();
`ifdef CORDIC_RESBUF_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
